// File: rtl/fu_wb_arbiter.sv
// rtl/fu_wb_arbiter.sv - write-back arbiter: per-FU holding slots, round-robin grant to one port
module fu_wb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_FU*ID_W-1:0]   fu_finish,
    input  logic [NUM_FU*DATA_W-1:0] fu_res,
    input  logic [NUM_FU-1:0]        fu_ovf,
    input  logic                     wb_ready,
    output logic                     wb_valid,
    output logic [ID_W-1:0]          wb_fu_id,
    output logic [DATA_W-1:0]        wb_data,
    output logic                     wb_ovf,
    output logic [NUM_FU-1:0]        slot_full,
    output logic                     drop_err
);

    localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0] full_q;
    logic [ID_W-1:0]   slot_id   [NUM_FU];
    logic [DATA_W-1:0] slot_data [NUM_FU];
    logic [NUM_FU-1:0] slot_ovf;
    logic [PTR_W-1:0]  ptr;
    logic              drop_q;

    logic              grant_found;
    logic [PTR_W-1:0]  grant_idx;
    logic [PTR_W:0]    probe;
    logic              xfer;
    logic [PTR_W:0]    next_ptr;

    // Round-robin search: first occupied slot at or after the pointer, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        probe       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            probe = {1'b0, ptr} + (PTR_W+1)'(k);
            if (probe >= (PTR_W+1)'(NUM_FU)) begin
                probe = probe - (PTR_W+1)'(NUM_FU);
            end
            if (!grant_found && full_q[probe[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = probe[PTR_W-1:0];
            end
        end
    end

    assign xfer = grant_found && wb_ready;

    always_comb begin
        next_ptr = {1'b0, grant_idx} + (PTR_W+1)'(1);
        if (next_ptr >= (PTR_W+1)'(NUM_FU)) begin
            next_ptr = '0;
        end
    end

    // Outputs come only from registered slot state, never from fu_* directly.
    always_comb begin
        wb_valid = grant_found;
        wb_fu_id = '0;
        wb_data  = '0;
        wb_ovf   = 1'b0;
        if (grant_found) begin
            wb_fu_id = slot_id[grant_idx];
            wb_data  = slot_data[grant_idx];
            wb_ovf   = slot_ovf[grant_idx];
        end
    end

    assign slot_full = full_q;
    assign drop_err  = drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            slot_ovf <= '0;
            ptr      <= '0;
            drop_q   <= 1'b0;
            for (int i = 0; i < NUM_FU; i++) begin
                slot_id[i]   <= '0;
                slot_data[i] <= '0;
            end
        end else begin
            if (xfer) begin
                ptr <= next_ptr[PTR_W-1:0];
            end
            for (int i = 0; i < NUM_FU; i++) begin
                // A slot being drained this edge may accept a new result without loss.
                if (fu_finish[i*ID_W +: ID_W] != '0) begin
                    if (!full_q[i] || (xfer && grant_idx == PTR_W'(i))) begin
                        full_q[i]    <= 1'b1;
                        slot_id[i]   <= fu_finish[i*ID_W +: ID_W];
                        slot_data[i] <= fu_res[i*DATA_W +: DATA_W];
                        slot_ovf[i]  <= fu_ovf[i];
                    end else begin
                        drop_q <= 1'b1;
                    end
                end else if (xfer && grant_idx == PTR_W'(i)) begin
                    full_q[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/fu_wb_arbiter.md
Name: fu_wb_arbiter

Overview:
- Write-back stage directly downstream of the functional units (ALU, MUL, DIV, MEM).
- Each FU presents a finish ID and a result for exactly one cycle. This block captures them into a one-entry holding slot per FU.
- It grants one slot per cycle to the single register-file / scoreboard write-back port using round-robin arbitration.
- It tells the issue stage which FUs must not be re-enabled while their slot is occupied.

Parameters:
- NUM_FU, 4, number of functional units (2..8)
- DATA_W, 32, result width
- ID_W, 4, FU identifier width; ID 0 means "no finish"

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- fu_finish  input  NUM_FU*ID_W  per-FU finish ID, slice i = FU i; nonzero means a result is valid this cycle
- fu_res  input  NUM_FU*DATA_W  per-FU result, sampled only when the matching finish is nonzero
- fu_ovf  input  NUM_FU  per-FU overflow flag, sampled with the result
- wb_ready  input  1  write-back consumer accepts the current wb_* this cycle
- wb_valid  output  1  a slot is granted and wb_* are valid
- wb_fu_id  output  ID_W  finish ID of the granted slot
- wb_data  output  DATA_W  result of the granted slot
- wb_ovf  output  1  overflow flag of the granted slot
- slot_full  output  NUM_FU  slot i is occupied; issue must not enable FU i while set
- drop_err  output  1  sticky flag: a finish arrived at a full slot that was not being drained

Behaviour:
- Reset (async, rst_n=0):
  - All slots empty; slot data, ID and ovf cleared to 0.
  - RR pointer = 0; drop_err = 0.
  - All outputs 0 immediately, independent of clk.
- Slot capture, on posedge clk for slot i:
  - Trigger: fu_finish slice i != 0.
  - Captured: ID, fu_res slice i and fu_ovf[i]; slot i becomes full.
- Latency: a finish in cycle t is visible on wb_* no earlier than cycle t+1.
- Never combinational pass-through from fu_* to wb_*.
- Arbitration (combinational from slot state and pointer):
  - Search slots starting at pointer p, ascending, wrapping modulo NUM_FU.
  - The first full slot is granted.
  - wb_valid = any slot full.
  - wb_fu_id, wb_data and wb_ovf come from the granted slot; all 0 when no slot is full.
- Handshake:
  - A transfer occurs when wb_valid && wb_ready at posedge.
  - The granted slot empties, and p becomes granted index + 1 (mod NUM_FU).
  - No transfer: p and all slots hold; wb_* remain stable while wb_valid && !wb_ready.
- Simultaneous drain and capture on the same slot in the same cycle: the new result is stored and the slot stays full. No drop; drop_err unchanged.
- Capture into a full slot that is not being drained:
  - The new data is discarded and the old slot contents are kept.
  - drop_err is set and stays 1 until reset.
- slot_full is the registered occupancy and reflects captures and drains from the previous edge.
- Throughput: at most one write-back per cycle. Multiple FUs finishing in the same cycle are all captured.
- Fairness: with all slots continuously full and wb_ready=1, each slot is granted once every NUM_FU cycles.
- Reset mid-operation: pending slots are lost without being written back; drop_err clears.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with slots 1 and 2 full -> wb_valid=0, slot_full=0000, drop_err=0 immediately.
- Single finish with wb_ready=1:
  - Stimulus: cycle 0, FU0 finish=4'h1, res=32'h0000_00AA.
  - Cycle 1: wb_valid=1, wb_fu_id=1, wb_data=32'hAA, slot_full=0001.
  - Cycle 2: wb_valid=0, slot_full=0000.
- Concurrent finishes and round-robin with p=0, wb_ready=1:
  - Stimulus: FU0..FU3 finish simultaneously with IDs 1..4 and data 10,20,30,40.
  - Cycles 1..4 deliver IDs 1,2,3,4 in order; then a new FU0 and FU1 pair delivers 1 then 2.
- Backpressure:
  - Stimulus: slot 2 full (ID 3, data 32'hDEAD_BEEF), wb_ready=0 for 3 cycles.
  - wb_* stay constant at ID 3 / DEADBEEF for 3 cycles; the transfer occurs on the first cycle with wb_ready=1.
- Drain-and-refill:
  - Stimulus: slot 1 granted with wb_ready=1 while FU1 finishes again with data 32'h55.
  - Slot 1 remains full holding 32'h55; drop_err=0.
- Drop:
  - Stimulus: slot 0 full, wb_ready=0, FU0 finishes with data 32'h77.
  - Slot 0 keeps its old data; drop_err=1 from the next cycle and stays 1 until rst_n=0.
